// File: rtl/guess_button_conditioner_if.sv
// Button conditioner bus: raw button levels in, cleaned guess code and strobes out.
//   btn_raw_i  raw asynchronous button levels, 1 = pressed
//   b_o        debounced button levels (guess code)
//   press_o    1-cycle strobe, code went all-zero -> nonzero
//   release_o  1-cycle strobe, code went nonzero -> all-zero
//   multi_o    level, more than one bit of the code set
// master: board/test side driving buttons; slave: the conditioner.
interface guess_button_conditioner_if #(
   parameter int unsigned N_BTN = 4
);
   logic [N_BTN-1:0] btn_raw_i;
   logic [N_BTN-1:0] b_o;
   logic             press_o;
   logic             release_o;
   logic             multi_o;

   modport master (
      output btn_raw_i,
      input  b_o,
      input  press_o,
      input  release_o,
      input  multi_o
   );

   modport slave (
      input  btn_raw_i,
      output b_o,
      output press_o,
      output release_o,
      output multi_o
   );
endinterface

// File: rtl/guess_button_conditioner.sv
// Synchronises and debounces N_BTN raw push-buttons into a stable level code for the
// guess game FSM, and derives press/release strobes and a multi-press flag from it.
//   clk    system clock, rising edge
//   reset  synchronous, active-low
//   bus    slave side of guess_button_conditioner_if (btn_raw_i in; b_o, press_o,
//          release_o, multi_o out)
module guess_button_conditioner #(
   parameter int unsigned N_BTN       = 4,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned DB_COUNT    = 1000000
) (
   input  logic                       clk,
   input  logic                       reset,
   guess_button_conditioner_if.slave  bus
);

   localparam int unsigned   CW     = $clog2(DB_COUNT);
   // Acceptance happens on the edge the counter would otherwise pass this value,
   // so the counter never wraps.
   localparam logic [CW-1:0] CntMax = CW'(DB_COUNT - 1);

   logic [N_BTN-1:0] sync_q [SYNC_STAGES];
   logic [N_BTN-1:0] s;
   logic [CW-1:0]    cnt_q  [N_BTN];
   logic [CW-1:0]    cnt_d  [N_BTN];
   logic [N_BTN-1:0] b_q, b_d;
   logic [N_BTN-1:0] b_prev_q;
   logic             press_q, press_d;
   logic             release_q, release_d;
   logic             multi_q, multi_d;
   int unsigned      ones;

   assign s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int st = 0; st < SYNC_STAGES; st++) begin
            sync_q[st] <= '0;
         end
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= '0;
         end
         b_q       <= '0;
         b_prev_q  <= '0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         multi_q   <= 1'b0;
      end else begin
         sync_q[0] <= bus.btn_raw_i;
         for (int st = 1; st < SYNC_STAGES; st++) begin
            sync_q[st] <= sync_q[st-1];
         end
         for (int i = 0; i < N_BTN; i++) begin
            cnt_q[i] <= cnt_d[i];
         end
         b_q       <= b_d;
         b_prev_q  <= b_q;
         press_q   <= press_d;
         release_q <= release_d;
         multi_q   <= multi_d;
      end
   end

   always_comb begin
      b_d  = b_q;
      ones = 0;
      for (int i = 0; i < N_BTN; i++) begin
         // Any sample agreeing with the accepted level restarts the hold window.
         cnt_d[i] = '0;
         if (s[i] != b_q[i]) begin
            if (cnt_q[i] == CntMax) begin
               b_d[i] = s[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
         ones = ones + 32'(b_q[i]);
      end
      // Strobes compare the current code against last cycle's, so they land one
      // edge after b changes; nonzero -> other nonzero changes give neither.
      press_d   = (b_prev_q == '0) && (b_q != '0);
      release_d = (b_prev_q != '0) && (b_q == '0);
      multi_d   = (ones >= 2);
   end

   assign bus.b_o       = b_q;
   assign bus.press_o   = press_q;
   assign bus.release_o = release_q;
   assign bus.multi_o   = multi_q;

endmodule

// File: tb/tb_guess_button_conditioner.sv
module tb_guess_button_conditioner;

   typedef struct {
      logic [3:0] raw;
      logic [3:0] b;
      logic       p;
      logic       r;
      logic       m;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;
   vec_t vecs[$];

   guess_button_conditioner_if #(.N_BTN(4)) bus ();

   guess_button_conditioner #(
      .N_BTN      (4),
      .SYNC_STAGES(2),
      .DB_COUNT   (4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [3:0] b, input logic p,
                            input logic r, input logic m);
      check({tag, ".b"}, bus.b_o, b);
      check({tag, ".press"}, {3'b0, bus.press_o}, {3'b0, p});
      check({tag, ".release"}, {3'b0, bus.release_o}, {3'b0, r});
      check({tag, ".multi"}, {3'b0, bus.multi_o}, {3'b0, m});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [3:0] raw, input logic [3:0] b, input logic p,
                       input logic r, input logic m);
      vec_t v;
      v.raw = raw; v.b = b; v.p = p; v.r = r; v.m = m;
      vecs.push_back(v);
   endtask

   // Raw level applied from edge j0: b flips at j5, strobe at j6, multi follows at j6.
   task automatic seg(input logic [3:0] raw, input logic [3:0] b_old, input logic [3:0] b_new,
                      input logic p, input logic r, input logic m_old, input logic m_new);
      for (int j = 0; j < 5; j++) push(raw, b_old, 1'b0, 1'b0, m_old);
      push(raw, b_new, 1'b0, 1'b0, m_old);
      push(raw, b_new, p, r, m_new);
      push(raw, b_new, 1'b0, 1'b0, m_new);
   endtask

   initial begin
      checks   = 0;
      failures = 0;

      // Idle, then a 3-cycle glitch on bit 2 that must be rejected.
      push(4'b0000, 4'b0000, 0, 0, 0);
      push(4'b0000, 4'b0000, 0, 0, 0);
      for (int j = 0; j < 3; j++) push(4'b0100, 4'b0000, 0, 0, 0);
      for (int j = 0; j < 4; j++) push(4'b0000, 4'b0000, 0, 0, 0);
      // Full hold after the glitch still needs 5 edges (counter was cleared).
      seg(4'b0100, 4'b0000, 4'b0100, 1, 0, 0, 0);
      seg(4'b0000, 4'b0100, 4'b0000, 0, 1, 0, 0);
      seg(4'b0001, 4'b0000, 4'b0001, 1, 0, 0, 0);
      seg(4'b0000, 4'b0001, 4'b0000, 0, 1, 0, 0);
      // Two bits accepted together: single update, one press, multi next cycle.
      seg(4'b1010, 4'b0000, 4'b1010, 1, 0, 0, 1);
      // Nonzero to different nonzero: no strobe, multi drops.
      seg(4'b1000, 4'b1010, 4'b1000, 0, 0, 1, 0);
      seg(4'b0000, 4'b1000, 4'b0000, 0, 1, 0, 0);
      push(4'b0000, 4'b0000, 0, 0, 0);
      push(4'b0000, 4'b0000, 0, 0, 0);

      // Reset held with all buttons pressed: everything stays zero.
      reset         = 1'b0;
      bus.btn_raw_i = 4'b1111;
      for (int j = 0; j < 3; j++) begin
         tick();
         check_all($sformatf("reset%0d", j), 4'b0000, 0, 0, 0);
      end
      reset         = 1'b1;
      bus.btn_raw_i = 4'b0000;

      foreach (vecs[n]) begin
         bus.btn_raw_i = vecs[n].raw;
         tick();
         check_all($sformatf("vec%0d", n), vecs[n].b, vecs[n].p, vecs[n].r, vecs[n].m);
      end

      // Reset in the middle of a debounce discards progress.
      bus.btn_raw_i = 4'b1000;
      for (int j = 0; j < 2; j++) begin
         tick();
         check_all($sformatf("mid%0d", j), 4'b0000, 0, 0, 0);
      end
      reset = 1'b0;
      for (int j = 0; j < 2; j++) begin
         tick();
         check_all($sformatf("midrst%0d", j), 4'b0000, 0, 0, 0);
      end
      reset = 1'b1;
      for (int j = 0; j < 5; j++) begin
         tick();
         check_all($sformatf("after%0d", j), 4'b0000, 0, 0, 0);
      end
      tick();
      check_all("after5", 4'b1000, 0, 0, 0);
      tick();
      check_all("after6", 4'b1000, 1, 0, 0);
      tick();
      check_all("after7", 4'b1000, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
